// File: rtl/page_responder.sv
// Page-value query responder: queues owned-page queries in a small FIFO and
// answers each with the live local node value through a one-entry output register.
module page_responder #(
   parameter int N     = 16,
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         ant_id,
   input  logic [N*WIDTH-1:0] node_vals,
   input  logic               q_valid,
   output logic               q_ready,
   input  logic [1:0]         q_src,
   input  logic [5:0]         q_page,
   output logic               r_valid,
   input  logic               r_ready,
   output logic [1:0]         r_dst,
   output logic [5:0]         r_page,
   output logic [WIDTH-1:0]   r_val,
   output logic               err_foreign,
   output logic [15:0]        served_cnt
);

   localparam int            AW   = $clog2(DEPTH);
   localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

   typedef struct packed {
      logic [1:0] src;
      logic [5:0] page;
   } entry_t;

   entry_t             fifo_q [DEPTH];
   entry_t             fifo_d [DEPTH];
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [AW:0]        count_q, count_d;
   logic               r_valid_q, r_valid_d;
   logic [1:0]         r_dst_q, r_dst_d;
   logic [5:0]         r_page_q, r_page_d;
   logic [WIDTH-1:0]   r_val_q, r_val_d;
   logic               err_q, err_d;
   logic [15:0]        served_q, served_d;

   logic               accept;
   logic               own_page;
   logic               push;
   logic               load;
   logic               r_fire;
   entry_t             head;
   logic [WIDTH-1:0]   head_val;

   // Ready depends only on the registered count; a pop in the same cycle does not free a slot early.
   assign q_ready  = (count_q < FULL);
   assign accept   = q_valid & q_ready;
   assign own_page = (q_page[5:4] == ant_id);
   assign push     = accept & own_page;
   assign r_fire   = r_valid_q & r_ready;
   assign load     = (count_q != '0) & (~r_valid_q | r_ready);
   assign head     = fifo_q[rd_ptr_q];

   always_comb begin
      head_val = '0;
      for (int k = 0; k < N; k++) begin
         if (head.page[3:0] == k[3:0]) begin
            head_val = node_vals[k*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         fifo_d[wr_ptr_q] = '{src: q_src, page: q_page};
         wr_ptr_d         = wr_ptr_q + AW'(1);
      end
      if (load) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, load})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Value is captured when the entry moves into the output register, not at query acceptance.
   always_comb begin
      r_valid_d = r_valid_q;
      r_dst_d   = r_dst_q;
      r_page_d  = r_page_q;
      r_val_d   = r_val_q;
      if (load) begin
         r_valid_d = 1'b1;
         r_dst_d   = head.src;
         r_page_d  = head.page;
         r_val_d   = head_val;
      end else if (r_fire) begin
         r_valid_d = 1'b0;
      end
      err_d    = err_q | (accept & ~own_page);
      served_d = served_q + {15'd0, r_fire};
   end

   always_ff @(posedge clk) begin
      fifo_q <= fifo_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         r_valid_q <= 1'b0;
         r_dst_q   <= '0;
         r_page_q  <= '0;
         r_val_q   <= '0;
         err_q     <= 1'b0;
         served_q  <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         r_valid_q <= r_valid_d;
         r_dst_q   <= r_dst_d;
         r_page_q  <= r_page_d;
         r_val_q   <= r_val_d;
         err_q     <= err_d;
         served_q  <= served_d;
      end
   end

   assign r_valid     = r_valid_q;
   assign r_dst       = r_dst_q;
   assign r_page      = r_page_q;
   assign r_val       = r_val_q;
   assign err_foreign = err_q;
   assign served_cnt  = served_q;

endmodule
